// File: rtl/io_event_controller.sv
// io_event_controller: queues 16-bit external events and presents the head on
// the CPU input port. Each queued event gets a one-cycle interrupt pulse. The
// event is retired when the CPU toggles bit 15 of its output port.
// Optional feature macro: IO_EVT_TIMEOUT_EN re-pulses the interrupt after
// TIMEOUT unacknowledged WAIT_ACK cycles and counts those re-pulses.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | waiting for a queued event
//   PULSE    | o_interrupt high for this one cycle; an ack is honoured
//   WAIT_ACK | waiting for the bit-15 toggle (optionally timed out)
//   HOLDOFF  | post-ack spacing, timer counts GAP down to 0, then IDLE
module io_event_controller #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int GAP     = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_event_valid,
  input  logic [15:0]            i_event_data,
  output logic                   o_event_ready,
  output logic                   o_interrupt,
  output logic [15:0]            o_input_port,
  input  logic [15:0]            i_output_port,
  output logic [$clog2(DEPTH):0] o_pending,
  output logic                   o_overflow,
  output logic [7:0]             o_retry_count
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (TIMEOUT > GAP + 1) ? TIMEOUT : GAP + 1;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {IDLE, PULSE, WAIT_ACK, HOLDOFF} state_t;

  state_t          state, state_n;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [TW-1:0]   timer, timer_n;
  logic            ack_prev, ack, full, empty, push, pop;
  logic            unused_port_bits;
`ifdef IO_EVT_TIMEOUT_EN
  logic            retry;
`endif

  assign full             = (count == CW'(DEPTH));
  assign empty            = (count == '0);
  assign ack              = i_output_port[15] ^ ack_prev;
  assign push             = i_event_valid & ~full;
  assign o_event_ready    = ~full;
  assign o_pending        = count;
  assign o_input_port     = empty ? 16'h0000 : mem[rd_ptr];
  assign o_interrupt      = (state == PULSE);
  assign unused_port_bits = ^i_output_port[14:0];

  // Next-state logic; the shared down-counter serves both holdoff and timeout.
  always_comb begin
    state_n = state;
    timer_n = timer;
    pop     = 1'b0;
`ifdef IO_EVT_TIMEOUT_EN
    retry   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!empty) state_n = PULSE;
      end
      PULSE, WAIT_ACK: begin
        if (ack) begin
          pop = !empty;
          if (GAP == 0) begin
            state_n = IDLE;
          end else begin
            state_n = HOLDOFF;
            timer_n = TW'(GAP);
          end
        end else if (state == PULSE) begin
          state_n = WAIT_ACK;
`ifdef IO_EVT_TIMEOUT_EN
          timer_n = TW'(TIMEOUT - 1);
`endif
        end
`ifdef IO_EVT_TIMEOUT_EN
        else if (timer == '0) begin
          state_n = PULSE;
          retry   = 1'b1;
        end else begin
          timer_n = timer - TW'(1);
        end
`endif
      end
      HOLDOFF: begin
        if (timer == '0) state_n = IDLE;
        else timer_n = timer - TW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  // State, pointers, occupancy, ack edge history and sticky overflow.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      timer      <= '0;
      ack_prev   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      ack_prev <= i_output_port[15];
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (i_event_valid && full) o_overflow <= 1'b1;
    end
  end

  // Payload storage; contents are masked by empty so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_event_data;
  end

`ifdef IO_EVT_TIMEOUT_EN
  // Saturating count of timeout re-pulses.
  always_ff @(posedge i_clk) begin
    if (i_reset) o_retry_count <= 8'd0;
    else if (retry && o_retry_count != 8'hFF) o_retry_count <= o_retry_count + 8'd1;
  end
`else
  assign o_retry_count = 8'd0;
`endif

endmodule

// File: tb/tb_io_event_controller.sv
// Directed bench for io_event_controller (DEPTH=4, TIMEOUT=8, GAP=2).
module tb_io_event_controller;
  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_event_valid;
  logic [15:0] i_event_data;
  logic        o_event_ready;
  logic        o_interrupt;
  logic [15:0] o_input_port;
  logic [15:0] i_output_port;
  logic [2:0]  o_pending;
  logic        o_overflow;
  logic [7:0]  o_retry_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic b15 = 1'b0;

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic        tog;
    logic        ready;
    logic        intr;
    logic [15:0] port;
    logic [2:0]  pend;
    logic        ovf;
  } vec_t;
  vec_t vecs[$];

  io_event_controller #(.DEPTH(4), .TIMEOUT(8), .GAP(2)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_event_valid(i_event_valid),
    .i_event_data(i_event_data), .o_event_ready(o_event_ready),
    .o_interrupt(o_interrupt), .o_input_port(o_input_port),
    .i_output_port(i_output_port), .o_pending(o_pending),
    .o_overflow(o_overflow), .o_retry_count(o_retry_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic toggle_ack();
    b15 = ~b15;
    i_output_port = {b15, 15'h0};
  endtask

  task automatic wait_pulse(input int limit, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!o_interrupt && cycles < limit);
    chk("pulse seen", {31'd0, o_interrupt}, 32'd1);
  endtask

  function automatic void add(logic v, logic [15:0] d, logic t, logic r, logic it,
                              logic [15:0] p, logic [2:0] pn, logic ov);
    vecs.push_back('{v, d, t, r, it, p, pn, ov});
  endfunction

  initial begin
    int cyc;
    int hits;

    // single event, then ignored ack while idle and empty
    add(1, 16'h1234, 0, 1, 0, 16'h1234, 1, 0);
    add(0, 16'h0000, 0, 1, 1, 16'h1234, 1, 0);
    add(0, 16'h0000, 0, 1, 0, 16'h1234, 1, 0);
    add(0, 16'h0000, 1, 1, 0, 16'h0000, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 16'h0, 0, 1, 0, 16'h0, 0, 0);
    add(0, 16'h0000, 1, 1, 0, 16'h0000, 0, 0);
    add(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0);
    // fill with five events, fifth dropped
    add(1, 16'hA001, 0, 1, 0, 16'hA001, 1, 0);
    add(1, 16'hA002, 0, 1, 1, 16'hA001, 2, 0);
    add(1, 16'hA003, 0, 1, 0, 16'hA001, 3, 0);
    add(1, 16'hA004, 0, 0, 0, 16'hA001, 4, 0);
    add(1, 16'hA005, 0, 0, 0, 16'hA001, 4, 1);
    // drain in order, pulses GAP+3 apart
    add(0, 16'h0000, 1, 1, 0, 16'hA002, 3, 1);
    for (int k = 0; k < 3; k++) add(0, 16'h0, 0, 1, 0, 16'hA002, 3, 1);
    add(0, 16'h0000, 0, 1, 1, 16'hA002, 3, 1);
    add(0, 16'h0000, 1, 1, 0, 16'hA003, 2, 1);
    for (int k = 0; k < 3; k++) add(0, 16'h0, 0, 1, 0, 16'hA003, 2, 1);
    add(0, 16'h0000, 0, 1, 1, 16'hA003, 2, 1);
    add(0, 16'h0000, 1, 1, 0, 16'hA004, 1, 1);
    for (int k = 0; k < 3; k++) add(0, 16'h0, 0, 1, 0, 16'hA004, 1, 1);
    add(0, 16'h0000, 0, 1, 1, 16'hA004, 1, 1);
    add(0, 16'h0000, 1, 1, 0, 16'h0000, 0, 1);
    for (int k = 0; k < 4; k++) add(0, 16'h0, 0, 1, 0, 16'h0000, 0, 1);

    // reset held for two cycles
    i_reset = 1'b1;
    i_event_valid = 1'b0;
    i_event_data = 16'h0;
    i_output_port = 16'h0;
    step();
    step();
    chk("rst ready", {31'd0, o_event_ready}, 32'd1);
    chk("rst int", {31'd0, o_interrupt}, 32'd0);
    chk("rst port", {16'd0, o_input_port}, 32'd0);
    chk("rst pend", {29'd0, o_pending}, 32'd0);
    chk("rst ovf", {31'd0, o_overflow}, 32'd0);
    chk("rst retry", {24'd0, o_retry_count}, 32'd0);
    i_reset = 1'b0;

    // vector table
    for (int i = 0; i < vecs.size(); i++) begin
      i_event_valid = vecs[i].valid;
      i_event_data  = vecs[i].data;
      if (vecs[i].tog) b15 = ~b15;
      i_output_port = {b15, 15'(i * 3)};
      step();
      chk($sformatf("vec%0d ready", i), {31'd0, o_event_ready}, {31'd0, vecs[i].ready});
      chk($sformatf("vec%0d int", i), {31'd0, o_interrupt}, {31'd0, vecs[i].intr});
      chk($sformatf("vec%0d port", i), {16'd0, o_input_port}, {16'd0, vecs[i].port});
      chk($sformatf("vec%0d pend", i), {29'd0, o_pending}, {29'd0, vecs[i].pend});
      chk($sformatf("vec%0d ovf", i), {31'd0, o_overflow}, {31'd0, vecs[i].ovf});
    end
    i_event_valid = 1'b0;
    i_output_port = {b15, 15'h0};

    // push coinciding with ack, two queued
    i_event_valid = 1'b1; i_event_data = 16'hC001;
    step();
    i_event_data = 16'hC002;
    step();
    chk("sim pulse", {31'd0, o_interrupt}, 32'd1);
    chk("sim pend2", {29'd0, o_pending}, 32'd2);
    i_event_data = 16'hC003;
    toggle_ack();
    step();
    i_event_valid = 1'b0;
    chk("sim pend", {29'd0, o_pending}, 32'd2);
    chk("sim head", {16'd0, o_input_port}, 32'h0000C002);
    wait_pulse(20, cyc);
    chk("sim spacing", cyc + 1, 32'd5);
    chk("sim head2", {16'd0, o_input_port}, 32'h0000C002);
    toggle_ack();
    step();
    chk("sim pop", {16'd0, o_input_port}, 32'h0000C003);
    chk("sim pend1", {29'd0, o_pending}, 32'd1);

    // reset mid-operation discards queue and clears overflow
    step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    chk("mrst pend", {29'd0, o_pending}, 32'd0);
    chk("mrst port", {16'd0, o_input_port}, 32'd0);
    chk("mrst ovf", {31'd0, o_overflow}, 32'd0);
    chk("mrst ready", {31'd0, o_event_ready}, 32'd1);
    step();
    chk("mrst idle", {31'd0, o_interrupt}, 32'd0);

    // unacknowledged event
    i_event_valid = 1'b1; i_event_data = 16'hD00D;
    step();
    i_event_valid = 1'b0;
    wait_pulse(5, cyc);
    chk("to first", cyc, 32'd1);
`ifdef IO_EVT_TIMEOUT_EN
    wait_pulse(20, cyc);
    chk("to spacing1", cyc, 32'd9);
    chk("to retry1", {24'd0, o_retry_count}, 32'd1);
    wait_pulse(20, cyc);
    chk("to spacing2", cyc, 32'd9);
    chk("to retry2", {24'd0, o_retry_count}, 32'd2);
    toggle_ack();
    step();
    chk("to pop", {29'd0, o_pending}, 32'd0);
    for (int k = 0; k < 12; k++) step();
    chk("to retry hold", {24'd0, o_retry_count}, 32'd2);
`else
    hits = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (o_interrupt) hits++;
    end
    chk("wait no repulse", hits, 32'd0);
    chk("wait retry", {24'd0, o_retry_count}, 32'd0);
    chk("wait pend", {29'd0, o_pending}, 32'd1);
    toggle_ack();
    step();
    chk("wait pop", {29'd0, o_pending}, 32'd0);
`endif
    chk("end port", {16'd0, o_input_port}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
